dm_access_master: RTL and testbench

- Load/store initiator that drives the word-addressed data memory port: `mem_write`, word-index `mem_addr`, `write_mem_data`, and the combinational `read_mem_data`.
- Takes byte-addressed CPU requests (byte/half/word, signed/unsigned) through a valid/ready handshake.
- Performs read-modify-write for sub-word stores and returns extracted/extended load data.
- Sits between the multi-cycle CPU datapath and data memory.

---
 rtl/dm_access_master_if.sv | 34 +++
 rtl/dm_access_master.sv | 143 ++++++++++++++
 tb/tb_dm_access_master.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/dm_access_master_if.sv
// Bundle of the CPU request/response handshake and the word-addressed
// data memory port around dm_access_master.
//   master : the access engine (dm_access_master)
//   slave  : the surrounding CPU datapath and data memory
interface dm_access_master_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] resp_rdata;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] write_mem_data;
  logic [31:0] read_mem_data;

  modport master (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  read_mem_data,
    output req_ready, resp_valid, resp_err, resp_rdata,
    output mem_write, mem_addr, write_mem_data
  );

  modport slave (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output read_mem_data,
    input  req_ready, resp_valid, resp_err, resp_rdata,
    input  mem_write, mem_addr, write_mem_data
  );
endinterface

// File: rtl/dm_access_master.sv
// Load/store initiator for the word-addressed data memory.
// Byte-addressed byte/half/word requests; sub-word stores use read-modify-write.
// Optional build macro DM_ACCESS_MISALIGN_TRAP_EN: misaligned half/word accesses
// complete with an error instead of being silently aligned.
module dm_access_master #(
  parameter int unsigned DM_WORDS = 256
) (
  input logic                clk,
  input logic                rst_n,
  dm_access_master_if.master bus
);

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

  state_t      state_q, state_d;
  logic        we_q, uns_q, err_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q, wdata_q, wbuf_q, rdata_q;

  logic        accept, misalign, out_of_range, req_err;
  logic [31:0] addr_al;

  // Insert the right-aligned store lane(s) into an existing word.
  function automatic logic [31:0] merge_lanes(input logic [31:0] old_word,
                                              input logic [31:0] data,
                                              input logic [1:0]  sz,
                                              input logic [1:0]  lo);
    merge_lanes = old_word;
    if (sz == 2'b00)
      merge_lanes[{lo, 3'b000} +: 8] = data[7:0];
    else if (sz == 2'b01)
      merge_lanes[{lo[1], 4'b0000} +: 16] = data[15:0];
    else
      merge_lanes = data;
  endfunction

  // Pull the addressed lane(s) out of a word and zero/sign-extend.
  function automatic logic [31:0] extract_lanes(input logic [31:0] word,
                                                input logic [1:0]  sz,
                                                input logic        uns,
                                                input logic [1:0]  lo);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{lo, 3'b000} +: 8];
    h = word[{lo[1], 4'b0000} +: 16];
    if (sz == 2'b00)
      extract_lanes = uns ? {24'h0, b} : {{24{b[7]}}, b};
    else if (sz == 2'b01)
      extract_lanes = uns ? {16'h0, h} : {{16{h[15]}}, h};
    else
      extract_lanes = word;
  endfunction

  // Request decode: alignment handling and error classification at accept time.
  always_comb begin
    accept   = bus.req_valid && (state_q == IDLE);
    addr_al  = bus.req_addr;
    misalign = 1'b0;
`ifdef DM_ACCESS_MISALIGN_TRAP_EN
    misalign = ((bus.req_size == 2'b01) && bus.req_addr[0]) ||
               ((bus.req_size == 2'b10) && (bus.req_addr[1:0] != 2'b00));
`else
    if (bus.req_size == 2'b01)
      addr_al[0] = 1'b0;
    else if (bus.req_size == 2'b10)
      addr_al[1:0] = 2'b00;
`endif
    out_of_range = (addr_al >> 2) >= DM_WORDS;
    req_err      = (bus.req_size == 2'b11) || misalign || out_of_range;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (req_err)                     state_d = RESP;
          else if (!bus.req_we)            state_d = RD;
          else if (bus.req_size == 2'b10)  state_d = WR;
          else                             state_d = RD;
        end
      end
      RD:      state_d = we_q ? WR : RESP;
      WR:      state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request latch, read capture / merge, and response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      size_q  <= 2'b00;
      addr_q  <= '0;
      wdata_q <= '0;
      wbuf_q  <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            we_q    <= bus.req_we;
            uns_q   <= bus.req_unsigned;
            size_q  <= bus.req_size;
            addr_q  <= addr_al;
            wdata_q <= bus.req_wdata;
            wbuf_q  <= bus.req_wdata;
            err_q   <= req_err;
            rdata_q <= '0;
          end
        end
        RD: begin
          if (we_q) wbuf_q  <= merge_lanes(bus.read_mem_data, wdata_q, size_q, addr_q[1:0]);
          else      rdata_q <= extract_lanes(bus.read_mem_data, size_q, uns_q, addr_q[1:0]);
        end
        RESP: begin
          err_q   <= 1'b0;
          rdata_q <= '0;
        end
        default: ;
      endcase
    end
  end

  assign bus.req_ready      = (state_q == IDLE);
  assign bus.mem_write      = (state_q == WR);
  assign bus.mem_addr       = ((state_q == RD) || (state_q == WR)) ? {2'b00, addr_q[31:2]} : '0;
  assign bus.write_mem_data = (state_q == WR) ? wbuf_q : '0;
  assign bus.resp_valid     = (state_q == RESP);
  assign bus.resp_err       = err_q;
  assign bus.resp_rdata     = rdata_q;

endmodule

// File: tb/tb_dm_access_master.sv
// Self-checking bench for dm_access_master: directed scenarios plus randomized
// requests compared against a byte-lane arithmetic model of data memory.
module tb_dm_access_master;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dm_access_master_if bus();

  dm_access_master #(.DM_WORDS(256)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Data memory: combinational read, write on posedge; backdoor port for preload.
  logic [31:0] dm [256];
  logic [31:0] ref_dm [256];
  logic        bd_we = 1'b0;
  logic [7:0]  bd_idx = '0;
  logic [31:0] bd_val = '0;

  assign bus.read_mem_data = (bus.mem_addr < 32'd256) ? dm[bus.mem_addr[7:0]] : 32'h0;

  always @(posedge clk) begin
    if (bd_we) dm[bd_idx] <= bd_val;
    else if (bus.mem_write && (bus.mem_addr < 32'd256)) dm[bus.mem_addr[7:0]] <= bus.write_mem_data;
  end

  int checks = 0;
  int failures = 0;

  logic        o_err;
  logic [31:0] o_rd, o_wa, o_wd;
  int          o_lat, o_wn;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic backdoor(input int unsigned idx, input logic [31:0] val);
    @(negedge clk);
    bd_we = 1'b1; bd_idx = idx[7:0]; bd_val = val;
    @(posedge clk);
    #1 bd_we = 1'b0;
    ref_dm[idx] = val;
  endtask

  // Reference: memory semantics expressed as byte-lane arithmetic.
  function automatic void model(input logic we, input logic [1:0] sz, input logic un,
                                input logic [31:0] a, input logic [31:0] wd,
                                output logic e_err, output logic [31:0] e_rd,
                                output int e_lat, output int e_wn,
                                output logic [31:0] e_wa, output logic [31:0] e_wd);
    logic [31:0] ea, old, v, m;
    int unsigned nb, sh;
    logic mis;
    ea = a; mis = 1'b0;
    nb = 32'd1 << sz;
    e_rd = '0; e_wn = 0; e_wa = '0; e_wd = '0; e_lat = 1;
`ifdef DM_ACCESS_MISALIGN_TRAP_EN
    mis = (sz != 2'b11) && ((a % nb) != 0);
`else
    if (sz != 2'b11) ea = a - (a % nb);
`endif
    e_err = (sz == 2'b11) || mis || ((ea / 4) >= 256);
    if (e_err) return;
    sh  = 8 * (ea % 4);
    m   = (nb == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nb)) - 1);
    old = ref_dm[ea / 4];
    if (!we) begin
      v = (old >> sh) & m;
      if (!un && nb < 4 && v[8 * nb - 1]) v = v | ~m;
      e_rd  = v;
      e_lat = 2;
    end else begin
      e_wn = 1;
      e_wa = ea / 4;
      e_wd = (old & ~(m << sh)) | ((wd & m) << sh);
      ref_dm[ea / 4] = e_wd;
      e_lat = (nb == 4) ? 2 : 3;
    end
  endfunction

  // Issue one request, observe until the response pulse (bounded).
  task automatic txn(input logic we, input logic [1:0] sz, input logic un,
                     input logic [31:0] a, input logic [31:0] wd);
    int n;
    @(negedge clk);
    n = 0;
    while (!bus.req_ready && n < 20) begin @(negedge clk); n++; end
    bus.req_valid = 1'b1; bus.req_we = we; bus.req_size = sz;
    bus.req_unsigned = un; bus.req_addr = a; bus.req_wdata = wd;
    @(posedge clk);
    o_lat = 0; o_wn = 0; o_wa = '0; o_wd = '0; o_err = 1'b0; o_rd = '0;
    while (o_lat < 10) begin
      @(negedge clk);
      bus.req_valid = 1'b0;
      o_lat++;
      if (bus.req_ready) break;
      if (bus.mem_write) begin o_wn++; o_wa = bus.mem_addr; o_wd = bus.write_mem_data; end
      if (bus.resp_valid) begin o_err = bus.resp_err; o_rd = bus.resp_rdata; break; end
    end
  endtask

  task automatic run(input string tag, input logic we, input logic [1:0] sz, input logic un,
                     input logic [31:0] a, input logic [31:0] wd);
    logic e_err; logic [31:0] e_rd, e_wa, e_wd; int e_lat, e_wn;
    model(we, sz, un, a, wd, e_err, e_rd, e_lat, e_wn, e_wa, e_wd);
    txn(we, sz, un, a, wd);
    chk({tag, "_lat"},  o_lat, e_lat);
    chk({tag, "_err"},  {31'h0, o_err}, {31'h0, e_err});
    chk({tag, "_rdata"}, o_rd, e_rd);
    chk({tag, "_nwrite"}, o_wn, e_wn);
    if (e_wn != 0) begin
      chk({tag, "_waddr"}, o_wa, e_wa);
      chk({tag, "_wdata"}, o_wd, e_wd);
      chk({tag, "_mem"}, dm[e_wa[7:0]], ref_dm[e_wa[7:0]]);
    end
    @(negedge clk);
    chk({tag, "_clr_valid"}, {31'h0, bus.resp_valid}, 32'h0);
    chk({tag, "_clr_rdata"}, bus.resp_rdata, 32'h0);
    chk({tag, "_clr_err"}, {31'h0, bus.resp_err}, 32'h0);
  endtask

  initial begin
    logic [31:0] r [2];
    int nresp, n;
    logic acc2, pend;
    logic [31:0] exp1, exp2;

    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'b00;
    bus.req_unsigned = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
    repeat (2) @(negedge clk);
    chk("rst_ready", {31'h0, bus.req_ready}, 32'h1);
    chk("rst_resp_valid", {31'h0, bus.resp_valid}, 32'h0);
    chk("rst_mem_write", {31'h0, bus.mem_write}, 32'h0);
    chk("rst_mem_addr", bus.mem_addr, 32'h0);
    chk("rst_wmd", bus.write_mem_data, 32'h0);
    chk("rst_rdata", bus.resp_rdata, 32'h0);
    rst_n = 1'b1;

    for (int unsigned i = 0; i < 16; i++) backdoor(i, $urandom);

    // Word store then load.
    run("sw10", 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
    chk("sw10_dir_addr", o_wa, 32'd4);
    chk("sw10_dir_data", o_wd, 32'hDEADBEEF);
    chk("sw10_dir_lat", o_lat, 2);
    run("lw10", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    chk("lw10_dir_rdata", o_rd, 32'hDEADBEEF);

    // Byte read-modify-write.
    backdoor(4, 32'h11223344);
    run("sb12", 1'b1, 2'b00, 1'b0, 32'h12, 32'h000000AB);
    chk("sb12_dir_data", o_wd, 32'h11AB3344);
    chk("sb12_dir_lat", o_lat, 3);

    run("lb12", 1'b0, 2'b00, 1'b0, 32'h12, 32'h0);
    chk("lb12_dir", o_rd, 32'hFFFFFFAB);
    run("lbu12", 1'b0, 2'b00, 1'b1, 32'h12, 32'h0);
    chk("lbu12_dir", o_rd, 32'h000000AB);
    run("lh12", 1'b0, 2'b01, 1'b0, 32'h12, 32'h0);
    chk("lh12_dir", o_rd, 32'h000011AB);

    run("lw12_mis", 1'b0, 2'b10, 1'b0, 32'h12, 32'h0);
`ifdef DM_ACCESS_MISALIGN_TRAP_EN
    chk("lw12_mis_dir_err", {31'h0, o_err}, 32'h1);
`else
    chk("lw12_mis_dir_rdata", o_rd, 32'h11AB3344);
`endif

    run("lw400", 1'b0, 2'b10, 1'b0, 32'h400, 32'h0);
    chk("lw400_dir_err", {31'h0, o_err}, 32'h1);
    chk("lw400_dir_lat", o_lat, 1);
    run("rsvd", 1'b0, 2'b11, 1'b0, 32'h8, 32'h0);
    chk("rsvd_dir_err", {31'h0, o_err}, 32'h1);

    // Reset during the write cycle of a sub-word store.
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_size = 2'b00;
    bus.req_unsigned = 1'b0; bus.req_addr = 32'h11; bus.req_wdata = 32'h5A;
    @(posedge clk);
    n = 0;
    do begin @(negedge clk); bus.req_valid = 1'b0; n++; end while (!bus.mem_write && n < 10);
    chk("rstmid_reached_wr", {31'h0, bus.mem_write}, 32'h1);
    rst_n = 1'b0;
    #1;
    chk("rstmid_mem_write", {31'h0, bus.mem_write}, 32'h0);
    chk("rstmid_mem_addr", bus.mem_addr, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("rstmid_ready", {31'h0, bus.req_ready}, 32'h1);
    chk("rstmid_dm_unchanged", dm[4], ref_dm[4]);

    // Back-to-back with req_valid held high.
    exp1 = ref_dm[4];
    exp2 = ref_dm[8];
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_size = 2'b10;
    bus.req_unsigned = 1'b0; bus.req_addr = 32'h10;
    @(posedge clk);
    @(negedge clk);
    bus.req_addr = 32'h20;
    nresp = 0; acc2 = 1'b0; pend = 1'b0; r[0] = '0; r[1] = '0;
    for (int c = 0; c < 15; c++) begin
      if (c != 0) @(negedge clk);
      if (pend) begin bus.req_valid = 1'b0; pend = 1'b0; end
      if (bus.resp_valid && nresp < 2) begin r[nresp] = bus.resp_rdata; nresp++; end
      if (bus.req_ready && bus.req_valid && !acc2) begin
        chk("b2b_no_overlap", nresp, 1);
        acc2 = 1'b1; pend = 1'b1;
      end
    end
    bus.req_valid = 1'b0;
    chk("b2b_second_accepted", {31'h0, acc2}, 32'h1);
    chk("b2b_nresp", nresp, 2);
    chk("b2b_r0", r[0], exp1);
    chk("b2b_r1", r[1], exp2);

    // Randomized traffic.
    for (int k = 0; k < 80; k++) begin
      logic [1:0]  sz;
      logic [31:0] a;
      sz = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      a  = ($urandom_range(0, 9) == 0) ? (32'h400 + $urandom_range(0, 4095)) : 32'($urandom_range(0, 63));
      run("rnd", 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
